// File: rtl/adc_avg_frontend.sv
// ADC front end: settle, average 2^LOG2_AVG signed samples, subtract offset, saturate.
// The result is held stable on ADC_OUT until the next completed conversion.
module adc_avg_frontend #(
   parameter int FP_WIDTH      = 32,
   parameter int INT_WIDTH     = 16,
   parameter int ADC_BITS      = 14,
   parameter int LOG2_AVG      = 3,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                ADC_CLK,
   input  logic                RST_N,
   input  logic                ADC_EN,
   input  logic                ADC_VALID,
   input  logic [ADC_BITS-1:0] ADC_RAW,
   input  logic [FP_WIDTH-1:0] ADC_OFFSET,
   output logic [FP_WIDTH-1:0] ADC_OUT,
   output logic                ADC_DONE,
   output logic                BUSY,
   output logic                SAT
);
   localparam int FRAC  = FP_WIDTH - INT_WIDTH;
   localparam int ACC_W = ADC_BITS + LOG2_AVG;
   localparam int SHIFT = FRAC - (ADC_BITS - 1) - LOG2_AVG;
   localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam int SMP_W = LOG2_AVG + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_ACCUM  = 3'd2;
   localparam logic [2:0] S_SCALE  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   generate
      if (FRAC < ADC_BITS - 1 + LOG2_AVG) begin : g_bad_format
         $error("adc_avg_frontend: FRAC too small for ADC_BITS and LOG2_AVG");
      end
   endgenerate

   logic [2:0]          r_state;
   logic [2:0]          w_next_state;
   logic [CNT_W-1:0]    r_settle;
   logic [SMP_W-1:0]    r_smp;
   logic [ACC_W-1:0]    r_acc;
   logic [FP_WIDTH-1:0] r_out;
   logic                r_sat;
   logic                r_done;
   logic                r_busy;

   logic [ACC_W-1:0]    w_acc_add;
   logic [FP_WIDTH:0]   w_acc_ext;
   logic [FP_WIDTH:0]   w_scaled;
   logic [FP_WIDTH:0]   w_diff;
   logic                w_ovf;
   logic [FP_WIDTH-1:0] w_result;

   assign w_acc_add = r_acc + {{LOG2_AVG{ADC_RAW[ADC_BITS-1]}}, ADC_RAW};
   assign w_acc_ext = {{(FP_WIDTH + 1 - ACC_W){r_acc[ACC_W-1]}}, r_acc};
   assign w_scaled  = w_acc_ext << SHIFT;
   assign w_diff    = w_scaled - {ADC_OFFSET[FP_WIDTH-1], ADC_OFFSET};
   // The FP_WIDTH+1 difference overflows the output exactly when its top two bits differ.
   assign w_ovf     = w_diff[FP_WIDTH] ^ w_diff[FP_WIDTH-1];

   always_comb begin
      w_result = w_diff[FP_WIDTH-1:0];
      if (w_ovf) begin
         w_result = w_diff[FP_WIDTH] ? {1'b1, {(FP_WIDTH-1){1'b0}}}
                                     : {1'b0, {(FP_WIDTH-1){1'b1}}};
      end else begin
         w_result = w_diff[FP_WIDTH-1:0];
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (ADC_EN) w_next_state = (SETTLE_CYCLES == 0) ? S_ACCUM : S_SETTLE;
            else        w_next_state = S_IDLE;
         end
         S_SETTLE: begin
            if (!ADC_EN)                      w_next_state = S_IDLE;
            else if (r_settle == CNT_W'(1))   w_next_state = S_ACCUM;
            else                              w_next_state = S_SETTLE;
         end
         S_ACCUM: begin
            if (!ADC_EN) w_next_state = S_IDLE;
            else if (ADC_VALID && (r_smp == SMP_W'(2 ** LOG2_AVG - 1))) w_next_state = S_SCALE;
            else w_next_state = S_ACCUM;
         end
         S_SCALE: w_next_state = ADC_EN ? S_DONE : S_IDLE;
         S_DONE:  w_next_state = ADC_EN ? S_DONE : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge ADC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= S_IDLE;
         r_settle <= '0;
         r_smp    <= '0;
         r_acc    <= '0;
         r_out    <= '0;
         r_sat    <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state == S_SETTLE) || (w_next_state == S_ACCUM) ||
                    (w_next_state == S_SCALE);
         r_done  <= (r_state == S_DONE) && ADC_EN;
         case (r_state)
            S_IDLE: begin
               r_settle <= CNT_W'(SETTLE_CYCLES);
               r_smp    <= '0;
               r_acc    <= '0;
            end
            S_SETTLE: r_settle <= r_settle - CNT_W'(1);
            S_ACCUM: begin
               if (ADC_EN && ADC_VALID) begin
                  r_acc <= w_acc_add;
                  r_smp <= r_smp + SMP_W'(1);
               end
            end
            // An abort in SCALE leaves the previous result and SAT untouched.
            S_SCALE: begin
               if (ADC_EN) begin
                  r_out <= w_result;
                  r_sat <= w_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign ADC_OUT  = r_out;
   assign ADC_DONE = r_done;
   assign BUSY     = r_busy;
   assign SAT      = r_sat;
endmodule

// File: tb/tb_adc_avg_frontend.sv
// Scoreboard bench for adc_avg_frontend: default build plus a SETTLE_CYCLES=0 build.
module tb_adc_avg_frontend;
   logic        clk = 1'b0;
   logic        rst_n, en, en0, valid;
   logic [13:0] raw;
   logic [31:0] ofs;
   logic [31:0] out, out0;
   logic        done, busy, sat, done0, busy0, sat0;
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {
      logic [31:0] out;
      logic        sat;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   adc_avg_frontend dut (
      .ADC_CLK(clk), .RST_N(rst_n), .ADC_EN(en), .ADC_VALID(valid), .ADC_RAW(raw),
      .ADC_OFFSET(ofs), .ADC_OUT(out), .ADC_DONE(done), .BUSY(busy), .SAT(sat));

   adc_avg_frontend #(.SETTLE_CYCLES(0)) dut0 (
      .ADC_CLK(clk), .RST_N(rst_n), .ADC_EN(en0), .ADC_VALID(valid), .ADC_RAW(raw),
      .ADC_OFFSET(ofs), .ADC_OUT(out0), .ADC_DONE(done0), .BUSY(busy0), .SAT(sat0));

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // mode 0/3: +0x0400, mode 1: -8192, mode 2: alternating +8191/-8192
   function automatic logic [13:0] smp(input int mode, input int s);
      case (mode)
         1:       return 14'h2000;
         2:       return (s % 2 == 0) ? 14'h1FFF : 14'h2000;
         default: return 14'h0400;
      endcase
   endfunction

   // Runs one conversion on dut (which=0) or dut0 (which=1); leaves ADC_EN high.
   task automatic run_conv(input int which, input int mode, input logic [31:0] ofs_v,
                           input logic [31:0] exp_out, input logic exp_sat,
                           input int exp_lat, input int exp_busy, input string tag);
      exp_t e;
      int   cyc, s, c, busy_n, acc_start;
      logic got, d, b;
      ofs = ofs_v;
      e.out = exp_out;
      e.sat = exp_sat;
      sb.push_back(e);
      acc_start = (which == 0) ? 18 : 2;
      if (which == 0) en = 1'b1; else en0 = 1'b1;
      cyc = 0; s = 0; busy_n = 0; got = 1'b0;
      while (!got && cyc < 200) begin
         c = cyc + 1;
         if (c < acc_start) begin
            raw = 14'h1FFF; valid = 1'b1;
         end else if (s < 8 && (mode != 3 || (c - acc_start) % 3 == 0)) begin
            raw = smp(mode, s); valid = 1'b1; s++;
         end else begin
            raw = 14'h1FFF; valid = (s >= 8);
         end
         @(posedge clk); #1;
         cyc++;
         d = (which == 0) ? done : done0;
         b = (which == 0) ? busy : busy0;
         if (b) busy_n++;
         if (d) begin
            got = 1'b1;
            e = sb.pop_front();
            check({tag, "_out"}, (which == 0) ? out : out0, e.out);
            check({tag, "_sat"}, (which == 0) ? sat : sat0, e.sat);
         end
      end
      if (!got) void'(sb.pop_front());
      check({tag, "_lat"}, cyc - 1, exp_lat);
      check({tag, "_busy"}, busy_n, exp_busy);
   endtask

   task automatic end_conv(input int which, input string tag);
      if (which == 0) en = 1'b0; else en0 = 1'b0;
      @(posedge clk); #1;
      check({tag, "_donefall"}, (which == 0) ? done : done0, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic ab_done, hold_bad;
      rst_n = 1'b0; en = 1'b0; en0 = 1'b0; valid = 1'b0; raw = 14'h0; ofs = 32'h0;
      #12;
      check("rst_out", out, 32'h0);
      check("rst_flags", {done, busy, sat}, 3'b000);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      run_conv(0, 0, 32'h0, 32'h0000_2000, 1'b0, 26, 25, "t1");           end_conv(0, "t1");
      run_conv(0, 1, 32'h0, 32'hFFFF_0000, 1'b0, 26, 25, "t2_neg1");      end_conv(0, "t2a");
      run_conv(0, 2, 32'h0, 32'hFFFF_FFFC, 1'b0, 26, 25, "t2_alt");       end_conv(0, "t2b");
      run_conv(0, 0, 32'h0000_2000, 32'h0, 1'b0, 26, 25, "t3_zero");      end_conv(0, "t3a");
      run_conv(0, 0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 26, 25, "t3_pos"); end_conv(0, "t3b");
      run_conv(0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 26, 25, "t3_neg"); end_conv(0, "t3c");
      run_conv(0, 0, 32'h8000_2001, 32'h7FFF_FFFF, 1'b0, 26, 25, "t3_edge"); end_conv(0, "t3d");
      run_conv(0, 3, 32'h0, 32'h0000_2000, 1'b0, 40, 39, "t4_sparse");     end_conv(0, "t4");

      // Abort in ACCUM: prior result 0x2000/SAT=0 must survive.
      ofs = 32'h0; en = 1'b1; raw = 14'h1FFF; valid = 1'b1;
      repeat (20) @(posedge clk);
      #1 en = 1'b0;
      @(posedge clk); #1;
      check("t5_abort_busy", busy, 1'b0);
      ab_done = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done) ab_done = 1'b1;
      end
      check("t5_abort_done", ab_done, 1'b0);
      check("t5_abort_out", out, 32'h0000_2000);
      check("t5_abort_sat", sat, 1'b0);

      run_conv(0, 1, 32'h0, 32'hFFFF_0000, 1'b0, 26, 25, "t5_after");
      hold_bad = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (busy || !done || out !== 32'hFFFF_0000) hold_bad = 1'b1;
      end
      check("t5_hold", hold_bad, 1'b0);
      end_conv(0, "t5");

      run_conv(1, 0, 32'h0, 32'h0000_2000, 1'b0, 10, 9, "t6_settle0");   end_conv(1, "t6a");

      // Async reset between edges in the middle of ACCUM.
      run_conv(0, 0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 26, 25, "t6_pre"); end_conv(0, "t6b");
      en = 1'b1; raw = 14'h0400; valid = 1'b1;
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t6_rst_out", out, 32'h0);
      check("t6_rst_flags", {done, busy, sat}, 3'b000);
      check("t6_rst_out0", out0, 32'h0);
      en = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
